// File: rtl/extend_pkg.sv
// Shared definitions for the immediate-extension unit.
//   IMM_W / WORD_W   : immediate and datapath word widths
//   ext_op_e         : extOp encodings (2'b11 is reserved and decodes as plain)
//   ext_imm()        : the extension function itself, so the core and any
//                      future user (e.g. a decoder-side preview) agree on it
package extend_pkg;

   localparam int IMM_W  = 16;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      EXT_PLAIN  = 2'b00,
      EXT_LUI    = 2'b01,
      EXT_BRANCH = 2'b10,
      EXT_RSVD   = 2'b11
   } ext_op_e;

   function automatic logic [WORD_W-1:0] ext_imm(
      input logic [IMM_W-1:0] imm,
      input logic             sign_ext,
      input logic [1:0]       op
   );
      logic [WORD_W-1:0] res;
      res = '0;
      case (op)
         EXT_LUI:    res = {imm, 16'h0000};
         // Branch offsets are always signed, word-aligned (<<2).
         EXT_BRANCH: res = {{14{imm[IMM_W-1]}}, imm, 2'b00};
         // Plain and the reserved encoding share the same path.
         default:    res = sign_ext ? {{16{imm[IMM_W-1]}}, imm}
                                    : {16'h0000, imm};
      endcase
      return res;
   endfunction

endpackage

// File: rtl/extend_core.sv
// Purely combinational immediate extension.
// Ports:
//   din     [15:0] in  : instruction immediate field
//   extSign        in  : 1 = sign-extend, 0 = zero-extend (plain mode only)
//   extOp   [1:0]  in  : 00 plain, 01 LUI, 10 branch offset, 11 as plain
//   res_o   [31:0] out : extended 32-bit operand
module extend_core
   import extend_pkg::*;
(
   input  logic [IMM_W-1:0]  din,
   input  logic              extSign,
   input  logic [1:0]        extOp,
   output logic [WORD_W-1:0] res_o
);

   always_comb begin
      res_o = ext_imm(din, extSign, extOp);
   end

endmodule

// File: rtl/extend.sv
// Immediate-extension unit with a registered ID->EX output stage.
// Ports:
//   clk            in  : rising-edge clock
//   rst_n          in  : synchronous active-low reset, wins over in_valid
//   in_valid       in  : din/extSign/extOp are valid this cycle
//   din     [15:0] in  : immediate field
//   extSign        in  : 1 = sign-extend, 0 = zero-extend
//   extOp   [1:0]  in  : 00 plain, 01 LUI, 10 branch, 11 reserved (plain)
//   dout    [31:0] out : registered extended result, held when idle
//   out_valid      out : dout was captured from a valid input last cycle
module extend
   import extend_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [IMM_W-1:0]  din,
   input  logic              extSign,
   input  logic [1:0]        extOp,
   output logic [WORD_W-1:0] dout,
   output logic              out_valid
);

   logic [WORD_W-1:0] core_res;
   logic [WORD_W-1:0] dout_d, dout_q;
   logic              valid_d, valid_q;

   extend_core u_core (
      .din     (din),
      .extSign (extSign),
      .extOp   (extOp),
      .res_o   (core_res)
   );

   // Idle cycles keep the last result so downstream muxes see a stable value.
   always_comb begin
      dout_d  = in_valid ? core_res : dout_q;
      valid_d = in_valid;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dout_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         valid_q <= valid_d;
      end
   end

   assign dout      = dout_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_extend.sv
module tb_extend;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] din;
   logic        extSign;
   logic [1:0]  extOp;
   logic [31:0] dout;
   logic        out_valid;

   int vectors;
   int miscompares;

   extend dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din       (din),
      .extSign   (extSign),
      .extOp     (extOp),
      .dout      (dout),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [15:0] d, input logic s,
                        input logic [1:0] op);
      in_valid = v;
      din      = d;
      extSign  = s;
      extOp    = op;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 16'hFFFF, 1'b1, 2'b00);
      drive(1'b1, 16'hFFFF, 1'b1, 2'b00);
      vectors++;
      if (dout !== 32'h0000_0000 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: dout=%h valid=%b required dout=00000000 valid=0", dout, out_valid);
      end
      rst_n = 1'b1;
      drive(1'b1, 16'h1234, 1'b1, 2'b00);
      vectors++;
      if (dout !== 32'h0000_1234 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release: dout=%h valid=%b required dout=00001234 valid=1", dout, out_valid);
      end
   endtask

   task automatic test_plain();
      logic [15:0] d_tab [4] = '{16'h1234, 16'h1234, 16'hABCD, 16'hABCD};
      logic        s_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] e_tab [4] = '{32'h0000_1234, 32'h0000_1234,
                                 32'hFFFF_ABCD, 32'h0000_ABCD};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, d_tab[i], s_tab[i], 2'b00);
         vectors++;
         if (dout !== e_tab[i] || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL plain[%0d]: dout=%h valid=%b required dout=%h valid=1", i, dout, out_valid, e_tab[i]);
         end
      end
   endtask

   task automatic test_lui_branch();
      logic        s_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [1:0]  o_tab [5] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11};
      logic [31:0] e_tab [5] = '{32'h8001_0000, 32'h8001_0000,
                                 32'hFFFE_0004, 32'hFFFE_0004, 32'h0000_8001};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'h8001, s_tab[i], o_tab[i]);
         vectors++;
         if (dout !== e_tab[i] || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL lui_branch[%0d]: dout=%h valid=%b required dout=%h valid=1", i, dout, out_valid, e_tab[i]);
         end
      end
      // Reserved op with sign extension behaves as plain signed.
      drive(1'b1, 16'h8001, 1'b1, 2'b11);
      vectors++;
      if (dout !== 32'hFFFF_8001) begin
         miscompares++;
         $display("FAIL rsvd_signed: dout=%h required FFFF8001", dout);
      end
      // Positive branch offset.
      drive(1'b1, 16'h0003, 1'b0, 2'b10);
      vectors++;
      if (dout !== 32'h0000_000C) begin
         miscompares++;
         $display("FAIL branch_pos: dout=%h required 0000000C", dout);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 16'h7FFF, 1'b1, 2'b00);
      vectors++;
      if (dout !== 32'h0000_7FFF || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_first: dout=%h valid=%b required dout=00007FFF valid=1", dout, out_valid);
      end
      drive(1'b1, 16'h8000, 1'b1, 2'b00);
      vectors++;
      if (dout !== 32'hFFFF_8000 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_second: dout=%h valid=%b required dout=FFFF8000 valid=1", dout, out_valid);
      end
      drive(1'b0, 16'h1111, 1'b0, 2'b01);
      vectors++;
      if (dout !== 32'hFFFF_8000 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL hold: dout=%h valid=%b required dout=FFFF8000 valid=0", dout, out_valid);
      end
      drive(1'b0, 16'h2222, 1'b1, 2'b10);
      vectors++;
      if (dout !== 32'hFFFF_8000 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_ctrl_change: dout=%h valid=%b required dout=FFFF8000 valid=0", dout, out_valid);
      end
   endtask

   task automatic test_mid_reset();
      drive(1'b1, 16'h5555, 1'b1, 2'b01);
      vectors++;
      if (dout !== 32'h5555_0000 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_pre: dout=%h valid=%b required dout=55550000 valid=1", dout, out_valid);
      end
      rst_n = 1'b0;
      drive(1'b1, 16'h6666, 1'b0, 2'b00);
      vectors++;
      if (dout !== 32'h0000_0000 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: dout=%h valid=%b required dout=00000000 valid=0", dout, out_valid);
      end
      rst_n = 1'b1;
      drive(1'b0, 16'h7777, 1'b1, 2'b00);
      vectors++;
      if (dout !== 32'h0000_0000 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_no_stale: dout=%h valid=%b required dout=00000000 valid=0", dout, out_valid);
      end
      drive(1'b1, 16'hFFFE, 1'b1, 2'b10);
      vectors++;
      if (dout !== 32'hFFFF_FFF8 || out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_resume: dout=%h valid=%b required dout=FFFFFFF8 valid=1", dout, out_valid);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      din         = '0;
      extSign     = 1'b0;
      extOp       = 2'b00;
      test_reset();
      test_plain();
      test_lui_branch();
      test_back_to_back();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/extend.md
# extend

Immediate-extension unit for the MIPS datapath. Converts the 16-bit instruction immediate into a 32-bit operand for the ALU, the LUI path and branch-offset generation. Sits between the instruction register/decoder and the ALU-B / branch-adder muxes. Registered output stage with a valid flag, so the ID→EX boundary can use it directly.

## Interface
Parameters:
- none; widths fixed at 16 in, 32 out.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  din/extSign/extOp qualify this cycle
- din  input  16  immediate field
- extSign  input  1  1 = sign-extend, 0 = zero-extend
- extOp  input  2  00 = plain extend, 01 = LUI, 10 = branch offset, 11 = reserved (treated as 00)
- dout  output  32  extended result, registered
- out_valid  output  1  dout holds a result captured from a valid input

## Operation
- Plain (extOp=00 or 11):
  - extSign=1: dout = {16{din[15]}, din}.
  - extSign=0: dout = {16'h0000, din}.
- LUI (extOp=01): dout = {din, 16'h0000}; extSign ignored.
- Branch (extOp=10): dout = {14{din[15]}, din, 2'b00}, i.e. sign-extended then shifted left 2. extSign ignored (always signed).
- Pure bit manipulation; no arithmetic, no overflow conditions.
- in_valid=0: dout holds its previous value; out_valid falls to 0.
- No backpressure. Every valid input produces exactly one output one cycle later.

## Timing
- Latency: 1 cycle. Inputs sampled at rising edge N appear on dout/out_valid after edge N.
- Throughput: one result per cycle, back-to-back valid inputs allowed.
- Reset (rst_n=0 at a rising edge): dout ← 32'h0000_0000, out_valid ← 0. Reset takes priority over in_valid.
- Reset asserted mid-stream: the in-flight result is discarded. The first valid input after rst_n returns high produces output one cycle later.
- extSign/extOp changing while in_valid=0: no effect on outputs.

## Structure
- Shared package entries:
  - extOp encodings EXT_PLAIN=2'b00, EXT_LUI=2'b01, EXT_BRANCH=2'b10.
  - Width constants IMM_W=16, WORD_W=32.
- One natural sub-module, extend_core: a purely combinational function of din/extSign/extOp → 32-bit result.
- The top level wraps extend_core with the dout/out_valid register stage and reset logic.

## Test plan
- Reset: hold rst_n=0 with in_valid=1, din=16'hFFFF → dout=32'h0000_0000, out_valid=0. Release → next valid input appears after one cycle.
- Plain extend, positive value: extOp=00, din=16'h1234, extSign=1 → dout=32'h0000_1234. Same with extSign=0 → 32'h0000_1234.
- Plain extend, negative value: extOp=00, din=16'hABCD:
  - extSign=1 → 32'hFFFF_ABCD
  - extSign=0 → 32'h0000_ABCD
- LUI and branch with din=16'h8001:
  - extOp=01 → 32'h8001_0000 (both extSign values)
  - extOp=10 → 32'hFFFE_0004
  - extOp=11, extSign=0 → 32'h0000_8001
- Back-to-back and hold: valid inputs 16'h7FFF, 16'h8000 (extSign=1) on consecutive cycles → 32'h0000_7FFF, then 32'hFFFF_8000, out_valid=1 both cycles. Then in_valid=0 → dout holds 32'hFFFF_8000, out_valid=0.
- Mid-stream reset: valid input issued, rst_n=0 on the next edge → dout=0, out_valid=0. No stale result after reset is released.
